// File: rtl/stepper_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_ctrl
//
// Multi-channel stepper-motor pulse generator. Software issues per-channel move
// commands (direction, step count, half-period). Each channel runs its own FSM:
//   IDLE -> SETUP -> HIGH -> LOW -> (HIGH | IDLE)
// DIR/EN are driven SETUP_CYC cycles before the first STEP rising edge so the
// driver sees a stable direction. All pins (step_o/dir_o/en_o) come straight
// from flops.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready is combinational from state)
//   cmd_ch              target channel; out-of-range channels are swallowed
//   cmd_dir/steps/period move parameters (period 0 behaves as 1)
//   abort               per-channel level-sensitive stop request
//   step_o/dir_o/en_o   registered driver pins
//   busy                channel not IDLE
//   done                one-cycle end-of-move pulse
//
// Optional build macro STEPPER_LIMIT_EN adds:
//   limit_n             active-low end-stop switches (double-flop synchronised)
//   fault               sticky per-channel limit-hit flag, cleared on next
//                       accepted command to that channel
// -----------------------------------------------------------------------------
module stepper_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 20,
  parameter int SETUP_CYC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic [NUM_CH-1:0] abort,
`ifdef STEPPER_LIMIT_EN
  input  logic [NUM_CH-1:0] limit_n,
  output logic [NUM_CH-1:0] fault,
`endif
  output logic [NUM_CH-1:0] step_o,
  output logic [NUM_CH-1:0] dir_o,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

  // SETUP counts down from SETUP_CYC-1 to 0, giving exactly SETUP_CYC cycles.
  localparam logic [DIV_W-1:0] SETUP_LOAD = DIV_W'(SETUP_CYC - 1);

  logic [NUM_CH-1:0] ch_sel_s;   // one-hot decode of cmd_ch (all zero if out of range)
  logic [NUM_CH-1:0] idle_s;     // channel FSM in IDLE
  logic [NUM_CH-1:0] accept_s;   // command accepted into this channel this cycle
  logic [NUM_CH-1:0] stop_s;     // effective early-stop request

  // Out-of-range channel: no select bit is set, so ready stays high and
  // the command is dropped without touching any channel.
  assign cmd_ready = ~|(ch_sel_s & ~idle_s);
  assign accept_s  = {NUM_CH{cmd_valid}} & ch_sel_s & idle_s;

`ifdef STEPPER_LIMIT_EN
  logic [NUM_CH-1:0] lim_meta_q;
  logic [NUM_CH-1:0] lim_sync_q;

  // Two-flop synchroniser for the asynchronous end-stop switches (reset to inactive).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lim_meta_q <= {NUM_CH{1'b1}};
      lim_sync_q <= {NUM_CH{1'b1}};
    end else begin
      lim_meta_q <= limit_n;
      lim_sync_q <= lim_meta_q;
    end
  end

  // A synchronised limit behaves exactly like abort.
  assign stop_s = abort | ~lim_sync_q;
`else
  assign stop_s = abort;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] remain_q;   // steps still to issue, including the current one
    logic [DIV_W-1:0] reload_q;   // half-period reload value (P-1)
    logic [DIV_W-1:0] cnt_q;      // phase down-counter
    logic             step_q;
    logic             dir_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;
    logic             half_end_s;

    assign ch_sel_s[g] = (cmd_ch == 3'(g));
    assign idle_s[g]   = (state_q == ST_IDLE);
    assign half_end_s  = (cnt_q == '0);

    assign step_o[g] = step_q;
    assign dir_o[g]  = dir_q;
    assign en_o[g]   = en_q;
    assign busy[g]   = busy_q;
    assign done[g]   = done_q;

    // Per-channel move FSM with registered pin outputs.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        remain_q <= '0;
        reload_q <= '0;
        cnt_q    <= '0;
        step_q   <= 1'b0;
        dir_q    <= 1'b0;
        en_q     <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            step_q <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            if (accept_s[g]) begin
              dir_q    <= cmd_dir;
              remain_q <= cmd_steps;
              reload_q <= (cmd_period == '0) ? '0 : (cmd_period - DIV_W'(1));
              if (cmd_steps == '0) begin
                // Zero-length move: direction still updates, driver stays off.
                done_q <= 1'b1;
              end else begin
                state_q <= ST_SETUP;
                en_q    <= 1'b1;
                busy_q  <= 1'b1;
                cnt_q   <= SETUP_LOAD;
              end
            end
          end

          ST_SETUP: begin
            if (stop_s[g]) begin
              state_q <= ST_IDLE;
              step_q  <= 1'b0;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (half_end_s) begin
              state_q <= ST_HIGH;
              step_q  <= 1'b1;
              cnt_q   <= reload_q;
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end

          ST_HIGH: begin
            // Stop requests wait for the high phase to finish: no runt pulses.
            if (half_end_s) begin
              step_q <= 1'b0;
              cnt_q  <= reload_q;
              if (stop_s[g]) begin
                state_q <= ST_IDLE;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_LOW;
              end
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end

          ST_LOW: begin
            if (stop_s[g]) begin
              state_q <= ST_IDLE;
              step_q  <= 1'b0;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (half_end_s) begin
              if (remain_q <= CNT_W'(1)) begin
                // Last step issued; counter saturates at zero.
                remain_q <= '0;
                state_q  <= ST_IDLE;
                en_q     <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                remain_q <= remain_q - CNT_W'(1);
                state_q  <= ST_HIGH;
                step_q   <= 1'b1;
                cnt_q    <= reload_q;
              end
            end else begin
              cnt_q <= cnt_q - DIV_W'(1);
            end
          end

          default: begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

`ifdef STEPPER_LIMIT_EN
    logic fault_q;
    assign fault[g] = fault_q;

    // Sticky limit-hit flag: set when the end-stop is seen during a move.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        fault_q <= 1'b0;
      end else if (accept_s[g]) begin
        fault_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && !lim_sync_q[g]) begin
        fault_q <= 1'b1;
      end else begin
        fault_q <= fault_q;
      end
    end
`endif
  end

endmodule

// File: tb/tb_stepper_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_ctrl
//
// Directed self-checking bench for stepper_ctrl (NUM_CH=2, SETUP_CYC=4).
// Edges are numbered from the acceptance edge (edge 1); outputs are sampled on
// the falling edge that follows each numbered rising edge.
// -----------------------------------------------------------------------------
module tb_stepper_ctrl;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ch;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [19:0] cmd_period;
  logic [1:0]  abort;
  logic [1:0]  step_o;
  logic [1:0]  dir_o;
  logic [1:0]  en_o;
  logic [1:0]  busy;
  logic [1:0]  done;
`ifdef STEPPER_LIMIT_EN
  logic [1:0]  limit_n;
  logic [1:0]  fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stepper_ctrl #(
    .NUM_CH    (2),
    .CNT_W     (16),
    .DIV_W     (20),
    .SETUP_CYC (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
`ifdef STEPPER_LIMIT_EN
    .limit_n    (limit_n),
    .fault      (fault),
`endif
    .step_o     (step_o),
    .dir_o      (dir_o),
    .en_o       (en_o),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input int ch, input logic dir, input int steps, input int period);
    cmd_ch     = 3'(ch);
    cmd_dir    = dir;
    cmd_steps  = 16'(steps);
    cmd_period = 20'(period);
  endtask

  // Issue one move and check every cycle against the hand-computed end edge.
  // abort_k > 0 raises abort[ch] after edge abort_k and drops it at the end.
  task automatic run_move(input string name, input int ch, input logic dir, input int steps,
                          input int period, input int end_k, input int abort_k, input int ncyc);
    int   p;
    int   oc;
    logic e_step;
    logic e_en;
    logic e_done;
    p  = (period == 0) ? 1 : period;
    oc = 1 - ch;
    @(negedge clock);
    drive_cmd(ch, dir, steps, period);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      e_en   = (k < end_k);
      e_done = (k == end_k);
      e_step = (steps > 0) && (k >= 5) && (k < end_k) && (((k - 5) % (2 * p)) < p);
      check_eq($sformatf("%s_step_k%0d", name, k), 32'(step_o[ch]), 32'(e_step));
      check_eq($sformatf("%s_en_k%0d",   name, k), 32'(en_o[ch]),   32'(e_en));
      check_eq($sformatf("%s_busy_k%0d", name, k), 32'(busy[ch]),   32'(e_en));
      check_eq($sformatf("%s_done_k%0d", name, k), 32'(done[ch]),   32'(e_done));
      check_eq($sformatf("%s_dir_k%0d",  name, k), 32'(dir_o[ch]),  32'(dir));
      check_eq($sformatf("%s_other_k%0d", name, k),
               32'({step_o[oc], en_o[oc], done[oc]}), 32'd0);
      if (k == abort_k) abort[ch] = 1'b1;
    end
    abort = 2'b00;
  endtask

  initial begin
    int edge_n;
    int k_done;
    int cnt_done;
    int cnt_step;
    int seen;

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    abort      = 2'b00;
    drive_cmd(0, 1'b0, 0, 0);
`ifdef STEPPER_LIMIT_EN
    limit_n    = 2'b11;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state.
    check_eq("rst_step",  32'(step_o), 32'd0);
    check_eq("rst_dir",   32'(dir_o),  32'd0);
    check_eq("rst_en",    32'(en_o),   32'd0);
    check_eq("rst_busy",  32'(busy),   32'd0);
    check_eq("rst_done",  32'(done),   32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);

    // ch0 dir=1 steps=3 period=2: done after edge 1+4+12 = 17.
    run_move("mv3", 0, 1'b1, 3, 2, 17, 0, 20);
    // ch1 zero steps: dir updates, done one cycle after acceptance.
    run_move("zero", 1, 1'b1, 0, 7, 1, 0, 3);
    // period 0 behaves as 1: done after edge 1+4+4 = 9.
    run_move("p0", 0, 1'b0, 2, 0, 9, 0, 11);
    // Abort mid-HIGH (HIGH spans edges 5..9): high completes, stop at edge 10.
    run_move("abort", 0, 1'b1, 100, 5, 10, 7, 14);

    // Out-of-range channel: ready high, no channel affected.
    @(negedge clock);
    drive_cmd(5, 1'b1, 3, 1);
    cmd_valid = 1'b1;
    #1 check_eq("oor_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("oor_busy", 32'(busy), 32'd0);
    check_eq("oor_done", 32'(done), 32'd0);

    // Stall: ch0 busy (steps=1 period=1, done after edge 7), ch1 goes through.
    @(negedge clock);
    drive_cmd(0, 1'b1, 1, 1);
    cmd_valid = 1'b1;
    @(posedge clock);                     // edge 1: ch0 accepted
    #1 drive_cmd(0, 1'b0, 2, 1);
    #1 check_eq("stall_ready", 32'(cmd_ready), 32'd0);
    @(posedge clock);                     // edge 2: held
    #1 drive_cmd(1, 1'b1, 1, 1);
    #1 check_eq("ch1_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);                     // edge 3: ch1 accepted
    #1 drive_cmd(0, 1'b0, 2, 1);
    @(negedge clock);
    check_eq("ch1_busy", 32'(busy[1]), 32'd1);
    check_eq("ch0_still_busy", 32'(busy[0]), 32'd1);
    edge_n = 3;
    k_done = 0;
    while (k_done == 0 && edge_n < 30) begin
      if (done[0]) k_done = edge_n;
      else begin
        @(negedge clock);
        edge_n++;
      end
    end
    check_eq("held_done_edge", 32'(k_done), 32'd7);
    check_eq("held_ready_in_done", 32'(cmd_ready), 32'd1);
    @(posedge clock);                     // edge 8: held ch0 command accepted
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("held_busy", 32'(busy[0]), 32'd1);
    check_eq("held_en",   32'(en_o[0]), 32'd1);
    check_eq("held_dir",  32'(dir_o[0]), 32'd0);
    check_eq("held_done_low", 32'(done[0]), 32'd0);
    @(negedge clock);                     // after edge 9: ch1 end
    check_eq("ch1_done", 32'(done[1]), 32'd1);
    repeat (12) @(negedge clock);
    check_eq("stall_idle", 32'(busy), 32'd0);

`ifdef STEPPER_LIMIT_EN
    // Limit hit during a 50-step move with period 3.
    @(negedge clock);
    drive_cmd(0, 1'b1, 50, 3);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (8) @(negedge clock);          // after edge 8
    limit_n = 2'b10;
    seen = 0;
    for (int k = 0; k < 6 && seen == 0; k++) begin
      @(negedge clock);
      if (done[0]) seen = 1;
    end
    check_eq("lim_stop_in_time", 32'(seen), 32'd1);
    check_eq("lim_fault", 32'(fault[0]), 32'd1);
    check_eq("lim_en_off", 32'(en_o[0]), 32'd0);
    check_eq("lim_fault_ch1", 32'(fault[1]), 32'd0);
    cnt_done = seen;
    cnt_step = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done[0]) cnt_done++;
      if (step_o[0]) cnt_step++;
    end
    check_eq("lim_done_once", 32'(cnt_done), 32'd1);
    check_eq("lim_no_step", 32'(cnt_step), 32'd0);
    limit_n = 2'b11;
    repeat (4) @(negedge clock);
    check_eq("lim_fault_sticky", 32'(fault[0]), 32'd1);
    drive_cmd(0, 1'b0, 0, 1);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("lim_fault_clear", 32'(fault[0]), 32'd0);
    check_eq("lim_zero_done", 32'(done[0]), 32'd1);
`endif

    // Asynchronous reset mid-move drops pins without a clock edge.
    @(negedge clock);
    drive_cmd(0, 1'b1, 5, 2);
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clock);          // after edge 5: first STEP high
    check_eq("pre_rst_step", 32'(step_o[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_step", 32'(step_o), 32'd0);
    check_eq("arst_en",   32'(en_o),   32'd0);
    check_eq("arst_dir",  32'(dir_o),  32'd0);
    check_eq("arst_busy", 32'(busy),   32'd0);
    check_eq("arst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_ctrl.md
# stepper_ctrl

Multi-channel stepper-motor pulse generator for the CPU-based motor-control system. It replaces the fixed enable/direction wiring and the free-running STEP clock divider. The processor issues per-channel move commands, each giving direction, step count and step half-period. The block produces registered STEP/DIR/EN pins with a guaranteed direction setup time, and reports busy/done status back to software.

## Interface
Parameters:
- NUM_CH, 2: number of independent motor channels (1..8)
- CNT_W, 16: width of step-count field
- DIV_W, 20: width of half-period field (clock cycles)
- SETUP_CYC, 4: cycles DIR/EN must be stable before the first STEP rising edge (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_ch  in  3  target channel; values >= NUM_CH are ignored (ready high, no effect)
- cmd_dir  in  1  direction for the move
- cmd_steps  in  CNT_W  number of STEP pulses
- cmd_period  in  DIV_W  STEP high time and low time, in cycles; 0 treated as 1
- abort  in  NUM_CH  per-channel stop request, level-sensitive
- step_o  out  NUM_CH  STEP pins, registered
- dir_o  out  NUM_CH  DIR pins, registered
- en_o  out  NUM_CH  driver enable, registered, high while moving
- busy  out  NUM_CH  channel not IDLE
- done  out  NUM_CH  one-cycle pulse at end of move (normal, zero-length or aborted)

## Operation
- Each channel has an independent FSM: IDLE -> SETUP -> HIGH -> LOW -> (HIGH | IDLE).
- cmd_ready = (cmd_ch >= NUM_CH) or channel cmd_ch in IDLE; combinational from registered state.
- Acceptance is (cmd_valid and cmd_ready). On acceptance the channel latches dir/steps/period.
  - Next cycle: dir_o and en_o are updated; state becomes SETUP.
  - If cmd_steps == 0: dir_o is updated, en_o stays low, done pulses next cycle, state stays IDLE.
- SETUP holds for SETUP_CYC cycles with step_o low, then goes to HIGH.
- HIGH: step_o high for the period in cycles, then LOW.
- LOW: step_o low for the period in cycles. At the end of LOW, remaining is decremented.
  - If remaining is now 0: done pulses, busy and en_o drop, state becomes IDLE.
  - Otherwise: HIGH.
- Half-period counter is DIV_W bits and reloads on every phase change. Step counter is CNT_W bits and never wraps below 0.
- abort[ch] high in SETUP or LOW: IDLE next cycle, step_o low, en_o low, done pulses.
- abort[ch] high in HIGH: the high phase completes (no runt pulse), then the abort is taken at the LOW entry.
- abort in IDLE has no effect. A command with abort held is accepted but ends after SETUP with zero steps.
- Commands to a busy channel stall (cmd_ready low). Other channels are unaffected.
- Reset mid-move: all outputs drop asynchronously; pulse truncation is permitted.

## Timing
- Reset values: step_o=0, dir_o=0, en_o=0, busy=0, done=0; all FSMs IDLE; cmd_ready=1.
- Accept at edge 0. dir_o/en_o/busy are valid after edge 1.
- First step_o rising edge is at edge 1+SETUP_CYC.
- done pulses in the cycle after edge 1+SETUP_CYC+2*P*N (P = max(period,1), N = steps).
- A new command to the same channel is acceptable in the same cycle done is high.
- All pin outputs come directly from flops; there are no combinational paths from inputs to pins.

## Configuration
- STEPPER_LIMIT_EN defined:
  - Adds input limit_n (NUM_CH bits, active-low end-stop switches), double-flop synchronised inside the block.
  - A synchronised limit active while busy behaves exactly as abort.
  - Sets a sticky fault bit per channel, exposed as output fault (NUM_CH). fault clears on the next accepted command to that channel.
  - A command accepted while limit is active ends with done and fault after SETUP, issuing zero steps.
- Not defined: limit_n and fault ports do not exist; the only early stop is abort.

## Test plan
- NUM_CH=2, SETUP_CYC=4, ch0 dir=1 steps=3 period=2:
  - dir_o[0]=1 and en_o[0]=1 after edge 1.
  - Exactly 3 step pulses, each 2 high / 2 low.
  - done[0] after edge 17; ch1 outputs stay 0.
- steps=0 on ch1 with dir=1 -> dir_o[1]=1, en_o[1] never high, no step, done[1] one cycle after acceptance.
- period=0, steps=2 -> pulses 1 high / 1 low; done after edge 1+4+4.
- Start ch0 (steps=100, period=5), assert abort[0] mid-HIGH:
  - step_o[0] completes its 5-cycle high and does not rise again.
  - en_o[0] drops and done[0] pulses once.
- Command ch0 while ch0 busy, then ch1 in the same cycle:
  - ch0 cmd_ready=0 and the command is held until done[0].
  - ch1 is accepted immediately.
  - The held ch0 command starts in its done cycle.
- STEPPER_LIMIT_EN: pull limit_n[0] low during a 50-step move:
  - Stop within 2+P cycles, fault[0]=1, done[0] once.
  - The next command clears fault[0].
